// File: rtl/pipe_delay_line.sv
// Multi-lane register delay line with per-entry valid and speculation tag,
// stall-in-place, flush, tag commit/kill and registered occupancy count.

module pipe_delay_line_lane #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 128
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_tag,
  input  logic               i_halt,
  input  logic               i_clear,
  input  logic               i_clear_tag,
  input  logic               i_delete_tag,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_tag,
  output logic [DEPTH-1:0]   o_nxt_valid
);
  logic [DEPTH-1:0]             vld_q, vld_d, tag_q, tag_d, prv_v, prv_t;
  logic [DEPTH-1:0][WIDTH-1:0]  dat_q, dat_d, prv_d;

  // Invalid input entries are normalised so stale payload never propagates.
  assign prv_v[0] = i_valid;
  assign prv_t[0] = i_valid & i_tag;
  assign prv_d[0] = i_valid ? i_data : '0;

  for (genvar s = 1; s < DEPTH; s++) begin : g_shift
    assign prv_v[s] = vld_q[s-1];
    assign prv_t[s] = tag_q[s-1];
    assign prv_d[s] = dat_q[s-1];
  end

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    dat_d = dat_q;
    if (!i_halt) begin
      vld_d = prv_v;
      tag_d = prv_t;
      dat_d = prv_d;
    end
    for (int s = 0; s < DEPTH; s++) begin
      if (i_delete_tag && tag_d[s]) begin
        vld_d[s] = 1'b0;
        tag_d[s] = 1'b0;
        dat_d[s] = '0;
      end
    end
    if (i_clear_tag) tag_d = '0;
    if (i_clear) begin
      vld_d = '0;
      tag_d = '0;
      dat_d = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      vld_q <= '0;
      tag_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      dat_q <= dat_d;
    end
  end

  assign o_valid     = vld_q[DEPTH-1];
  assign o_tag       = tag_q[DEPTH-1];
  assign o_data      = dat_q[DEPTH-1];
  assign o_nxt_valid = vld_d;
endmodule

module pipe_delay_line #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 1,
  parameter int WIDTH    = 128,
  localparam int CW      = $clog2(CHANNELS*DEPTH+1)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [CHANNELS-1:0]       i_valid,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic [CHANNELS-1:0]       i_tag,
  input  logic                      i_halt,
  input  logic                      i_clear,
  input  logic                      i_clear_tag,
  input  logic                      i_delete_tag,
  output logic [CHANNELS-1:0]       o_valid,
  output logic [CHANNELS*WIDTH-1:0] o_data,
  output logic [CHANNELS-1:0]       o_tag,
  output logic [CW-1:0]             o_count,
  output logic                      o_empty
);
  logic [CHANNELS-1:0][DEPTH-1:0] nxt_v;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic                           empty_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    pipe_delay_line_lane #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_lane (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_valid      (i_valid[k]),
      .i_data       (i_data[k*WIDTH +: WIDTH]),
      .i_tag        (i_tag[k]),
      .i_halt       (i_halt),
      .i_clear      (i_clear),
      .i_clear_tag  (i_clear_tag),
      .i_delete_tag (i_delete_tag),
      .o_valid      (o_valid[k]),
      .o_data       (o_data[k*WIDTH +: WIDTH]),
      .o_tag        (o_tag[k]),
      .o_nxt_valid  (nxt_v[k])
    );
  end

  // Count is taken from next-state valids so it lines up with the stages.
  always_comb begin
    cnt_d = '0;
    for (int k = 0; k < CHANNELS; k++)
      for (int s = 0; s < DEPTH; s++)
        cnt_d = cnt_d + CW'(nxt_v[k][s]);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q   <= '0;
      empty_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == '0);
    end
  end

  assign o_count = cnt_q;
  assign o_empty = empty_q;
endmodule

// File: tb/tb_pipe_delay_line.sv
// Randomised + directed bench: two delay lines (2x3 and 4x4) driven in lockstep
// and compared each cycle against a slot-array reference model.

module tb_pipe_delay_line;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   v, t;
  logic [127:0] d;
  logic         rst, h, clr, ct, dt;

  logic [1:0]   o_valid0, o_tag0;
  logic [63:0]  o_data0;
  logic [2:0]   o_count0;
  logic         o_empty0;
  logic [3:0]   o_valid1, o_tag1;
  logic [127:0] o_data1;
  logic [4:0]   o_count1;
  logic         o_empty1;

  pipe_delay_line #(.CHANNELS(2), .DEPTH(3), .WIDTH(32)) dut0 (
    .i_clock(clk), .i_reset(rst), .i_valid(v[1:0]), .i_data(d[63:0]), .i_tag(t[1:0]),
    .i_halt(h), .i_clear(clr), .i_clear_tag(ct), .i_delete_tag(dt),
    .o_valid(o_valid0), .o_data(o_data0), .o_tag(o_tag0), .o_count(o_count0), .o_empty(o_empty0));

  pipe_delay_line #(.CHANNELS(4), .DEPTH(4), .WIDTH(32)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_valid(v), .i_data(d), .i_tag(t),
    .i_halt(h), .i_clear(clr), .i_clear_tag(ct), .i_delete_tag(dt),
    .o_valid(o_valid1), .o_data(o_data1), .o_tag(o_tag1), .o_count(o_count1), .o_empty(o_empty1));

  typedef struct packed {
    logic [3:0]       v;
    logic [3:0]       t;
    logic [3:0][31:0] d;
  } slot_t;

  slot_t pipe [2][4];
  int n_chk = 0, n_fail = 0;

  function automatic int dep(int u); return (u == 0) ? 3 : 4; endfunction
  function automatic int nch(int u); return (u == 0) ? 2 : 4; endfunction

  task automatic chk(string tg, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tg, got, exp);
    end
  endtask

  // Each slot is one cycle's worth of lanes; advancing moves slots down the array.
  task automatic model_step(int u);
    slot_t in;
    if (rst || clr) begin
      for (int s = 0; s < 4; s++) pipe[u][s] = '0;
    end else begin
      if (!h) begin
        for (int s = dep(u) - 1; s > 0; s--) pipe[u][s] = pipe[u][s-1];
        in = '0;
        for (int k = 0; k < nch(u); k++)
          if (v[k]) begin
            in.v[k] = 1'b1;
            in.t[k] = t[k];
            in.d[k] = d[k*32 +: 32];
          end
        pipe[u][0] = in;
      end
      for (int s = 0; s < dep(u); s++)
        for (int k = 0; k < nch(u); k++) begin
          if (dt && pipe[u][s].t[k]) begin
            pipe[u][s].v[k] = 1'b0;
            pipe[u][s].t[k] = 1'b0;
            pipe[u][s].d[k] = '0;
          end else if (ct) begin
            pipe[u][s].t[k] = 1'b0;
          end
        end
    end
  endtask

  function automatic int mcount(int u);
    int c = 0;
    for (int s = 0; s < dep(u); s++) c += $countones(pipe[u][s].v);
    return c;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk("u0_valid", 128'(o_valid0), 128'(pipe[0][2].v));
    chk("u0_tag",   128'(o_tag0),   128'(pipe[0][2].t));
    chk("u0_data",  128'(o_data0),  128'(pipe[0][2].d));
    chk("u0_count", 128'(o_count0), 128'(mcount(0)));
    chk("u0_empty", 128'(o_empty0), 128'(mcount(0) == 0));
    chk("u1_valid", 128'(o_valid1), 128'(pipe[1][3].v));
    chk("u1_tag",   128'(o_tag1),   128'(pipe[1][3].t));
    chk("u1_data",  o_data1,        128'(pipe[1][3].d));
    chk("u1_count", 128'(o_count1), 128'(mcount(1)));
    chk("u1_empty", 128'(o_empty1), 128'(mcount(1) == 0));
  endtask

  task automatic idle_in();
    v = '0; t = '0; d = '0; h = 0; clr = 0; ct = 0; dt = 0; rst = 0;
  endtask

  int hold_cnt;

  initial begin
    for (int u = 0; u < 2; u++) for (int s = 0; s < 4; s++) pipe[u][s] = '0;
    idle_in();
    // reset with valid input present
    rst = 1; v = 4'hF; d = {4{32'hDEADBEEF}};
    cyc(); cyc();
    chk("rst_empty", 128'(o_empty0), 128'(1));
    chk("rst_count", 128'(o_count0), 128'(0));
    idle_in();
    cyc();

    // latency
    v = 4'b0011; d = {64'h0, 32'h1004, 32'h1000};
    cyc();
    idle_in();
    chk("lat_cnt1", 128'(o_count0), 128'(2));
    chk("lat_v1", 128'(o_valid0), 128'(0));
    cyc();
    chk("lat_cnt2", 128'(o_count0), 128'(2));
    cyc();
    chk("lat_v3", 128'(o_valid0), 128'(2'b11));
    chk("lat_d3", 128'(o_data0), 128'(64'h0000_1004_0000_1000));
    chk("lat_cnt3", 128'(o_count0), 128'(2));
    cyc();
    chk("lat_cnt4", 128'(o_count0), 128'(0));
    chk("lat_v4", 128'(o_valid0), 128'(0));

    // halt mid-stream
    hold_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      h = (i >= 2 && i < 6);
      v = (i < 5 || h) ? 4'hF : 4'h0;
      d = {4{32'(i) + 32'hA0}};
      cyc();
      if (i == 2) hold_cnt = int'(o_count0);
      if (i > 2 && i < 6) chk("halt_cnt", 128'(o_count0), 128'(hold_cnt));
    end
    idle_in();

    // delete tag with lane1 tagged
    v = 4'hF; t = 4'b1010;
    for (int i = 0; i < 3; i++) begin d = {4{$urandom}}; cyc(); end
    chk("del_pre", 128'(o_count0), 128'(6));
    dt = 1; d = {4{$urandom}};
    cyc();
    chk("del_cnt", 128'(o_count0), 128'(3));
    chk("del_v", 128'(o_valid0), 128'(2'b01));
    idle_in();

    // clear tag under halt
    v = 4'hF; t = 4'hF;
    for (int i = 0; i < 3; i++) begin d = {4{$urandom}}; cyc(); end
    idle_in(); ct = 1; h = 1;
    cyc();
    chk("ct_tag", 128'(o_tag0), 128'(0));
    chk("ct_v", 128'(o_valid0), 128'(2'b11));
    idle_in();

    // clear_tag and delete_tag together
    v = 4'hF; t = 4'b0101;
    for (int i = 0; i < 3; i++) begin d = {4{$urandom}}; cyc(); end
    ct = 1; dt = 1;
    cyc();
    chk("both_cnt", 128'(o_count0), 128'(3));
    chk("both_tag", 128'(o_tag0), 128'(0));
    idle_in();

    // clear while halted
    v = 4'hF; cyc(); cyc();
    clr = 1; h = 1;
    cyc();
    chk("clr_empty0", 128'(o_empty0), 128'(1));
    chk("clr_empty1", 128'(o_empty1), 128'(1));
    idle_in();

    // reset while full
    v = 4'hF;
    for (int i = 0; i < 4; i++) begin d = {4{$urandom}}; cyc(); end
    chk("full_cnt", 128'(o_count1), 128'(16));
    rst = 1;
    cyc();
    chk("mrst_cnt", 128'(o_count1), 128'(0));
    rst = 0; d = {32'h44, 32'h33, 32'h22, 32'h11};
    cyc();
    idle_in();
    cyc(); cyc();
    chk("mrst_v3", 128'(o_valid1), 128'(0));
    cyc();
    chk("mrst_v4", 128'(o_valid1), 128'(4'hF));
    chk("mrst_d4", o_data1, {32'h44, 32'h33, 32'h22, 32'h11});

    // random traffic
    for (int i = 0; i < 500; i++) begin
      v   = 4'($urandom);
      t   = 4'($urandom);
      d   = {$urandom, $urandom, $urandom, $urandom};
      h   = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 31) == 0);
      ct  = ($urandom_range(0, 9) == 0);
      dt  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
